// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port memory (LAT-cycle registered read) between IF and LS, one transaction at a time.
// Optional macro IMEM_ARB_RR_EN selects round-robin tie-break; otherwise LS wins ties.
module imem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req_valid,
  output logic              o_if_req_ready,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_rsp_valid,
  output logic [DATA_W-1:0] o_if_rsp_data,
  input  logic              i_ls_req_valid,
  output logic              o_ls_req_ready,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic              i_ls_we,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic [3:0]        i_ls_wmask,
  output logic              o_ls_rsp_valid,
  output logic [DATA_W-1:0] o_ls_rsp_data,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_wmask,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            r_state, w_next;
  logic [2:0]        r_cnt;
  logic              r_owner, r_we;
  logic [ADDR_W-3:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wmask;
  logic              w_idle, w_issue, w_resp, w_grant_ls, w_hs;
  logic              w_unused;
  assign w_unused = ^{i_if_addr[1:0], i_ls_addr[1:0]};
`ifdef IMEM_ARB_RR_EN
  logic r_last_ls;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last_ls <= 1'b1;
    else if (w_hs) r_last_ls <= w_grant_ls;
  assign w_grant_ls = i_ls_req_valid && (!i_if_req_valid || !r_last_ls);
`else
  assign w_grant_ls = i_ls_req_valid;
`endif
  always_comb begin
    w_idle         = r_state == IDLE;
    w_issue        = r_state == ISSUE;
    w_resp         = r_state == RESP;
    w_hs           = w_idle && (i_if_req_valid || i_ls_req_valid);
    w_next         = w_idle ? (w_hs ? ISSUE : IDLE) :
                     w_issue ? WAIT :
                     (r_state == WAIT) ? ((r_cnt == 3'(LAT - 1)) ? RESP : WAIT) : IDLE;
    // ready is masked during reset so every output reads 0 while rst_n is low
    o_if_req_ready = rst_n && w_idle && i_if_req_valid && !w_grant_ls;
    o_ls_req_ready = rst_n && w_idle && w_grant_ls;
    o_mem_en       = w_issue;
    o_mem_we       = w_issue && r_we;
    o_mem_addr     = w_issue ? r_addr : '0;
    o_mem_wdata    = w_issue ? r_wdata : '0;
    o_mem_wmask    = w_issue ? r_wmask : '0;
    o_if_rsp_valid = w_resp && !r_owner;
    o_ls_rsp_valid = w_resp && r_owner;
    o_if_rsp_data  = (w_resp && !r_owner) ? i_mem_rdata : '0;
    o_ls_rsp_data  = (w_resp && r_owner && !r_we) ? i_mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      r_cnt <= (r_state == WAIT) ? r_cnt + 3'd1 : 3'd0;
      if (w_hs) begin
        r_owner <= w_grant_ls;
        r_addr  <= w_grant_ls ? i_ls_addr[ADDR_W-1:2] : i_if_addr[ADDR_W-1:2];
        r_we    <= w_grant_ls && i_ls_we;
        r_wdata <= w_grant_ls ? i_ls_wdata : '0;
        r_wmask <= w_grant_ls ? i_ls_wmask : 4'd0;
      end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized + directed bench; transaction-level reference model feeds a scoreboard checked by a monitor.
module tb_imem_arbiter;
  localparam int LAT = 3;
  logic clk = 1'b0, rst_n = 1'b0, init = 1'b1;
  always #5 clk = ~clk;
  logic        if_v = 0, if_rdy, if_rv, ls_v = 0, ls_rdy, ls_we = 0, ls_rv;
  logic [31:0] if_a = 0, if_rd, ls_a = 0, ls_wd = 0, ls_rd, mem_wdata, mem_rdata;
  logic [3:0]  ls_wm = 0, mem_wmask;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req_valid(if_v), .o_if_req_ready(if_rdy), .i_if_addr(if_a),
    .o_if_rsp_valid(if_rv), .o_if_rsp_data(if_rd),
    .i_ls_req_valid(ls_v), .o_ls_req_ready(ls_rdy), .i_ls_addr(ls_a),
    .i_ls_we(ls_we), .i_ls_wdata(ls_wd), .i_ls_wmask(ls_wm),
    .o_ls_rsp_valid(ls_rv), .o_ls_rsp_data(ls_rd),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(int i);
    return (i == 2) ? 32'h00100093 : (i == 4) ? 32'h0 : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // memory instance: registered read held until the next enable, then LAT-1 extra stages
  logic [31:0] mem [64];
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    if (init) for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    else if (mem_en) begin
      pipe[0] <= mem[mem_addr[5:0]];
      if (mem_we) for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  typedef struct { logic ls; logic [31:0] data; int cyc; } rsp_t;
  typedef struct { logic [29:0] addr; logic we; logic [31:0] wd; logic [3:0] wm; int cyc; } mreq_t;
  rsp_t  rq[$];
  mreq_t mq[$];
  int checks = 0, errors = 0, cyc = 0, next_free = 0, g_if = 0, g_ls = 0;
  logic last_ls = 1'b1, hs_if, hs_ls, mon_en = 1'b0;
  logic [31:0] ref_mem [64];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endfunction

  // monitor: pops expected memory strobes and responses whenever the DUT presents them
  always @(negedge clk) if (rst_n && mon_en) begin
    mreq_t m;
    rsp_t  r;
    if (mem_en) begin
      if (mq.size() == 0) chk("mem_en_unexpected", 64'(mem_en), 64'(0));
      else begin
        m = mq.pop_front();
        chk("mem_cyc", 64'(cyc), 64'(m.cyc));
        chk("mem_addr", 64'(mem_addr), 64'(m.addr));
        chk("mem_we", 64'(mem_we), 64'(m.we));
        if (m.we) begin
          chk("mem_wdata", 64'(mem_wdata), 64'(m.wd));
          chk("mem_wmask", 64'(mem_wmask), 64'(m.wm));
        end
      end
    end else if (mq.size() > 0 && mq[0].cyc < cyc) begin
      chk("mem_en_missing", 64'(0), 64'(1));
      void'(mq.pop_front());
    end
    if (if_rv || ls_rv) begin
      chk("rsp_both", 64'(if_rv && ls_rv), 64'(0));
      if (rq.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
      else begin
        r = rq.pop_front();
        chk("rsp_owner", 64'(ls_rv), 64'(r.ls));
        chk("rsp_data", 64'(ls_rv ? ls_rd : if_rd), 64'(r.data));
        chk("rsp_cyc", 64'(cyc), 64'(r.cyc));
      end
    end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
      chk("rsp_missing", 64'(0), 64'(1));
      void'(rq.pop_front());
    end
  end

  // one cycle of stimulus; the model decides grant and queues the expected outcome
  task automatic step(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la,
                      input logic we, input logic [31:0] wd, input logic [3:0] wm);
    logic idle, eif, els, wr;
    logic [31:0] a, d;
    @(negedge clk);
    if_v = iv; if_a = ia; ls_v = lv; ls_a = la; ls_we = we; ls_wd = wd; ls_wm = wm;
    #1;
    idle = cyc >= next_free;
`ifdef IMEM_ARB_RR_EN
    els = idle && lv && (!iv || !last_ls);
`else
    els = idle && lv;
`endif
    eif = idle && iv && !els;
    chk("if_ready", 64'(if_rdy), 64'(eif));
    chk("ls_ready", 64'(ls_rdy), 64'(els));
    hs_if = iv && if_rdy;
    hs_ls = lv && ls_rdy;
    if (hs_if) g_if++;
    if (hs_ls) g_ls++;
    if (eif || els) begin
      a  = els ? la : ia;
      wr = els && we;
      d  = wr ? 32'h0 : ref_mem[a[7:2]];
      if (wr) for (int b = 0; b < 4; b++) if (wm[b]) ref_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
      mq.push_back('{addr: a[31:2], we: wr, wd: wd, wm: wm, cyc: cyc + 1});
      rq.push_back('{ls: els, data: d, cyc: cyc + LAT + 2});
      next_free = cyc + LAT + 3;
      last_ls = els;
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step_rand();
    step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
         1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({if_rdy, ls_rdy, if_rv, ls_rv, mem_en, mem_we, |mem_addr, |mem_wdata,
                |mem_wmask, |if_rd, |ls_rd});
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    if_v = 1; ls_v = 1;
    repeat (3) @(negedge clk);
    #1 chk("reset_outs", all_outs(), 64'(0));
    if_v = 0; ls_v = 0;
    @(negedge clk);
    init = 0; rst_n = 1; mon_en = 1;
    step(1, 32'h8, 0, 0, 0, 0, 0);
    chk("t1_if_hs", 64'(hs_if), 64'(1));
    idle_n(LAT + 3);
    step(0, 0, 1, 32'h10, 1, 32'hDEADBEEF, 4'b0011);
    chk("t2_wr_hs", 64'(hs_ls), 64'(1));
    idle_n(LAT + 3);
    step(0, 0, 1, 32'h10, 0, 0, 0);
    chk("t2_rd_hs", 64'(hs_ls), 64'(1));
    idle_n(LAT + 3);
    g_if = 0; g_ls = 0;
    for (int k = 0; k < 100 && (g_if + g_ls) < 6; k++) step(1, $urandom, 1, $urandom, 0, 0, 0);
`ifdef IMEM_ARB_RR_EN
    chk("tie_if_grants", 64'(g_if), 64'(3));
    chk("tie_ls_grants", 64'(g_ls), 64'(3));
`else
    chk("tie_if_grants", 64'(g_if), 64'(0));
    chk("tie_ls_grants", 64'(g_ls), 64'(6));
`endif
    idle_n(LAT + 4);
    step(1, 32'h20, 0, 0, 0, 0, 0);
    idle_n(2);
    step(1, 32'h24, 0, 0, 0, 0, 0);
    chk("drop_no_hs", 64'(hs_if), 64'(0));
    idle_n(LAT + 4);
    repeat (400) step_rand();
    idle_n(LAT + 4);
    step(1, 32'h8, 0, 0, 0, 0, 0);
    idle_n(2);
    @(negedge clk);
    rst_n = 0; if_v = 1;
    #1 chk("rst_mid_outs", all_outs(), 64'(0));
    if_v = 0;
    rq.delete(); mq.delete();
    next_free = 0; last_ls = 1'b1;
    @(negedge clk);
    rst_n = 1;
    idle_n(LAT + 4);
    step(1, 32'h8, 0, 0, 0, 0, 0);
    chk("post_rst_hs", 64'(hs_if), 64'(1));
    idle_n(LAT + 4);
    chk("rsp_queue_empty", 64'(rq.size()), 64'(0));
    chk("mem_queue_empty", 64'(mq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
